// File: rtl/arm1_booth_seq.sv
// ---------------------------------------------------------------------------
// arm1_booth_seq
//
// Radix-4 Booth multiply sequencer for MUL/MLA. It sits in front of the ALU
// datapath and issues one ALU operation per cycle. Each step tells the ALU
// whether to PASS, ADD or SUB the multiplicand. It also gives the left shift
// that the barrel shifter applies to the multiplicand. On the first step it
// selects the accumulator source (Rn for MLA, zero for MUL).
//
// Ports
//   clk         rising-edge system clock
//   n_reset     asynchronous active-low reset
//   start       multiply request, sampled only while idle
//   accumulate  1 = MLA (step 0 adds to Rn), 0 = MUL (step 0 adds to zero)
//   multiplier  Rs value, latched when start is accepted
//   hold        pipeline stall; freezes the sequencer while running
//   busy        high while steps are being issued
//   done        one-cycle pulse after the last step completes
//   alu_valid   a step is issued this cycle (low while stalled)
//   alu_fn      00 PASS, 01 ADD, 10 SUB
//   op2_shift   left shift applied to the multiplicand
//   acc_sel_rn  operand 1 is Rn (1) or zero (0); only meaningful on step 0
//   acc_we      accumulator write enable, identical to alu_valid
//   step_idx    current Booth step number
//
// Handshake: a step is offered whenever the sequencer is running. It is
// consumed on every rising edge where hold is low. While hold is high the
// step stays on the outputs and alu_valid/acc_we drop, so the ALU sees each
// step exactly once.
// ---------------------------------------------------------------------------
module arm1_booth_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH / 2,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             alu_valid,
    output logic [1:0]       alu_fn,
    output logic [CW-1:0]    op2_shift,
    output logic             acc_sel_rn,
    output logic             acc_we,
    output logic [CW-2:0]    step_idx
);

    localparam logic [1:0]    FN_PASS   = 2'b00;
    localparam logic [1:0]    FN_ADD    = 2'b01;
    localparam logic [1:0]    FN_SUB    = 2'b10;
    localparam logic [CW-2:0] LAST_STEP = (CW-1)'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Booth recoding of step idx. The result is {alu_fn, op2_shift}.
    // The triple {m[2i+1], m[2i], m[2i-1]} comes from the multiplier with a
    // zero appended below bit 0. The digits +-2 use the same multiplicand
    // shifted one place further rather than a separate 2M operand.
    // -----------------------------------------------------------------------
    function automatic logic [CW+1:0] recode(input logic [WIDTH-1:0] m,
                                             input logic [CW-2:0]    idx);
        logic [WIDTH:0] ext;
        logic [2:0]     t;
        logic [1:0]     fn;
        logic           dbl;
        ext = {m, 1'b0};
        t   = 3'(ext >> {idx, 1'b0});
        fn  = FN_PASS;
        dbl = 1'b0;
        case (t)
            3'b001, 3'b010: fn = FN_ADD;
            3'b011: begin
                fn  = FN_ADD;
                dbl = 1'b1;
            end
            3'b100: begin
                fn  = FN_SUB;
                dbl = 1'b1;
            end
            3'b101, 3'b110: fn = FN_SUB;
            default: fn = FN_PASS;
        endcase
        return {fn, {idx, 1'b0} + CW'(dbl)};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             acc_mode_q, acc_mode_d;
    logic [CW-2:0]    i_q, i_d;
    logic [1:0]       fn_q, fn_d;
    logic [CW-1:0]    shift_q, shift_d;
    logic             sel_q, sel_d;

    // Multiplier bits above 2i+1 down to 2i+1. Once these are all zero, every
    // remaining Booth digit is zero and the product is complete.
    logic [WIDTH-1:0] upper_bits;
    logic             last_step;

    assign upper_bits = m_q >> {i_q, 1'b1};
    assign last_step  = (upper_bits == '0) || (i_q == LAST_STEP);

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        acc_mode_d = acc_mode_q;
        i_d        = i_q;
        fn_d       = fn_q;
        shift_d    = shift_q;
        sel_d      = sel_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Step 0 is recoded straight from the incoming multiplier.
                    // This puts it on the outputs the cycle after acceptance.
                    state_d           = S_RUN;
                    m_d               = multiplier;
                    acc_mode_d        = accumulate;
                    i_d               = '0;
                    {fn_d, shift_d}   = recode(multiplier, '0);
                    sel_d             = accumulate;
                end
            end

            S_RUN: begin
                if (!hold) begin
                    if (last_step) begin
                        state_d = S_DONE;
                        i_d     = '0;
                        fn_d    = FN_PASS;
                        shift_d = '0;
                        sel_d   = 1'b0;
                    end else begin
                        // Only step 0 may take Rn; later steps accumulate.
                        i_d             = i_q + 1'b1;
                        {fn_d, shift_d} = recode(m_q, i_q + 1'b1);
                        sel_d           = 1'b0;
                    end
                end
            end

            S_DONE: begin
                // A single cycle, not extended by hold. A start seen here is
                // dropped; the requester must still hold start once idle.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                i_d     = '0;
                fn_d    = FN_PASS;
                shift_d = '0;
                sel_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            acc_mode_q <= 1'b0;
            i_q        <= '0;
            fn_q       <= FN_PASS;
            shift_q    <= '0;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            acc_mode_q <= acc_mode_d;
            i_q        <= i_d;
            fn_q       <= fn_d;
            shift_q    <= shift_d;
            sel_q      <= sel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Everything is taken from registers. The only exception is the
    // stall gate on alu_valid/acc_we: it must take effect in the cycle that
    // hold is raised, so that a frozen step is not written twice.
    // -----------------------------------------------------------------------
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign alu_valid  = busy && !hold;
    assign acc_we     = alu_valid;
    assign alu_fn     = fn_q;
    assign op2_shift  = shift_q;
    assign acc_sel_rn = sel_q;
    assign step_idx   = i_q;

endmodule

// File: tb/tb_arm1_booth_seq.sv
// ---------------------------------------------------------------------------
// tb_arm1_booth_seq
//
// Testbench for arm1_booth_seq. For each multiply, a reference model builds
// the expected list of steps from Booth digits:
//   d_i = m[2i] + m[2i-1] - 2*m[2i+1]
// The step count comes from the multiplier's top set bit. Issued steps are
// compared in order, and the issued terms are summed and checked against
// multiplier * multiplicand.
// ---------------------------------------------------------------------------
module tb_arm1_booth_seq;

  localparam int WIDTH = 32;
  localparam int STEPS = 16;
  localparam int CW    = 6;
  // Expected step record: {alu_fn[1:0], op2_shift[5:0], acc_sel_rn, step_idx[4:0]}
  localparam int W     = 14;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             n_reset;
  logic             start;
  logic             accumulate;
  logic [WIDTH-1:0] multiplier;
  logic             hold;
  logic             busy, done, alu_valid, acc_sel_rn, acc_we;
  logic [1:0]       alu_fn;
  logic [CW-1:0]    op2_shift;
  logic [CW-2:0]    step_idx;

  always #5 clk = ~clk;

  arm1_booth_seq #(.WIDTH(WIDTH), .STEPS(STEPS), .CW(CW)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .accumulate (accumulate),
    .multiplier (multiplier),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .alu_valid  (alu_valid),
    .alu_fn     (alu_fn),
    .op2_shift  (op2_shift),
    .acc_sel_rn (acc_sel_rn),
    .acc_we     (acc_we),
    .step_idx   (step_idx)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int booth_digit(input logic [31:0] m, input int i);
    int lo;
    lo = 0;
    if (i > 0) lo = int'(m[2*i-1]);
    return int'(m[2*i]) + lo - 2 * int'(m[2*i+1]);
  endfunction

  function automatic int n_steps(input logic [31:0] m);
    int msb;
    int n;
    msb = -1;
    for (int b = 31; b >= 0; b--) begin
      if (m[b] && msb < 0) msb = b;
    end
    if (msb < 0) return 1;
    n = (msb + 3) / 2;  // ceil((msb+2)/2)
    if (n > STEPS) n = STEPS;
    return n;
  endfunction

  function automatic logic [17:0] out_vec();
    return {busy, done, alu_valid, acc_we, alu_fn, op2_shift, acc_sel_rn, step_idx};
  endfunction

  // ---------------- driver ----------------
  // hold_step/hold_len: force hold for hold_len cycles while step hold_step is shown.
  // abort_at: pull reset low when step abort_at is shown (-1 = never).
  task automatic run_op(input logic [31:0] mv, input logic acc, input logic [31:0] mc,
                        input int hold_pct, input int hold_step, input int hold_len,
                        input int abort_at);
    int          n, issued, held, holds, cycles, d;
    logic        h;
    logic [31:0] sum, term;
    logic [W-1:0] e;
    logic [1:0]  fn;
    logic [5:0]  sh;

    exp_q.delete();
    n = n_steps(mv);
    for (int i = 0; i < n; i++) begin
      d  = booth_digit(mv, i);
      fn = (d > 0) ? 2'b01 : ((d < 0) ? 2'b10 : 2'b00);
      sh = 6'(2 * i + ((d == 2 || d == -2) ? 1 : 0));
      exp_q.push_back({fn, sh, acc && (i == 0), 5'(i)});
    end

    @(negedge clk);
    start      = 1'b1;
    multiplier = mv;
    accumulate = acc;
    hold       = 1'($urandom_range(0, 1));  // ignored while idle
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start      = 1'b0;
    multiplier = $urandom;  // must have been latched already
    accumulate = 1'($urandom_range(0, 1));

    issued = 0; held = 0; holds = 0; cycles = 0; sum = 32'd0;
    forever begin
      if (issued == abort_at) begin
        hold    = 1'b0;
        n_reset = 1'b0;
        #1;
        check("reset_outs", 32'(out_vec()), 32'd0);
        @(negedge clk);
        check("reset_held_outs", 32'(out_vec()), 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_idle", 32'({busy, done}), 32'd0);
        exp_q.delete();
        return;
      end
      if (issued == hold_step && held < hold_len) begin
        h = 1'b1;
        held++;
      end else begin
        h = ($urandom_range(0, 99) < hold_pct);
      end
      hold = h;
      #1;
      if (done) break;
      cycles++;
      if (cycles > 200) begin
        check("timeout_no_done", 32'd1, 32'd0);
        hold    = 1'b0;
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        exp_q.delete();
        return;
      end
      check("run_busy", 32'(busy), 32'd1);
      if (h) begin
        holds++;
        check("held_valid", 32'({alu_valid, acc_we}), 32'd0);
        if (exp_q.size() > 0)
          check("held_step", 32'({alu_fn, op2_shift, acc_sel_rn, step_idx}), 32'(exp_q[0]));
      end else begin
        check("issue_valid", 32'({alu_valid, acc_we}), 32'd3);
        if (exp_q.size() == 0) begin
          check("extra_step", 32'(step_idx), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("step", 32'({alu_fn, op2_shift, acc_sel_rn, step_idx}), 32'(e));
        end
        term = mc << op2_shift;
        if (alu_fn == 2'b01) sum = sum + term;
        if (alu_fn == 2'b10) sum = sum - term;
        issued++;
      end
      @(negedge clk);
    end

    // done cycle (hold is random here and must not extend it)
    check("done_flags", 32'({done, busy, alu_valid}), 32'b100);
    check("steps_left", 32'(exp_q.size()), 32'd0);
    check("product", sum, mv * mc);
    check("busy_cycles", 32'(cycles), 32'(n + holds));
    start = 1'($urandom_range(0, 1));  // a start during done is dropped
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    #1;
    check("done_pulse_end", 32'({done, busy}), 32'd0);
    @(negedge clk);
    #1;
    check("still_idle", 32'({done, busy}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_reset    = 1'b0;
    start      = 1'b0;
    accumulate = 1'b0;
    multiplier = '0;
    hold       = 1'b0;
    #7;
    check("reset_state", 32'(out_vec()), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    run_op(32'd0,          1'b0, $urandom, 0, -1, 0, -1);
    run_op(32'd3,          1'b0, $urandom, 0, -1, 0, -1);
    run_op(32'd2,          1'b1, $urandom, 0, -1, 0, -1);
    run_op(32'h8000_0000,  1'b0, $urandom, 0, -1, 0, -1);
    run_op(32'd5,          1'b0, $urandom, 0,  1, 3, -1);
    run_op(32'hFFFF_FFFF,  1'b0, $urandom, 0, -1, 0,  7);
    run_op(32'hFFFF_FFFF,  1'b1, $urandom, 0, -1, 0, -1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] mv;
      mv = $urandom >> $urandom_range(0, 31);
      run_op(mv, 1'($urandom_range(0, 1)), $urandom, 25, -1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
